// File: rtl/dc_derr_sched_pkg.sv
// dc_derr_sched_pkg: shared types and constants for the chroma DC
// error-diffusion sequencer (state enum, lane map, DERR widths).
package dc_derr_sched_pkg;

    localparam int DERR_W   = 8;
    localparam int WORD_W   = 32;
    localparam int BUNDLE_W = 48;
    localparam int Y_W      = 10;

    // Byte lanes of dp_derr placed in word bytes 3..0 (top line word)
    localparam int TOP_L3 = 5;
    localparam int TOP_L2 = 4;
    localparam int TOP_L1 = 2;
    localparam int TOP_L0 = 1;

    // Byte lanes of dp_derr placed in word bytes 3..0 (left neighbour)
    localparam int LEFT_L3 = 5;
    localparam int LEFT_L2 = 3;
    localparam int LEFT_L1 = 2;
    localparam int LEFT_L0 = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Gather four raw error bytes into one word; no arithmetic applied
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [BUNDLE_W-1:0] b,
        input int                  l3,
        input int                  l2,
        input int                  l1,
        input int                  l0
    );
        return {b[l3*DERR_W +: DERR_W],
                b[l2*DERR_W +: DERR_W],
                b[l1*DERR_W +: DERR_W],
                b[l0*DERR_W +: DERR_W]};
    endfunction

endpackage

// File: rtl/dc_derr_sched_line_ram.sv
// derr_line_ram: 1R1W per-column error line buffer.
// Registered read; a same-address read/write returns the old word.
module derr_line_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Storage array: contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register: holds the last read word until the next strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dc_derr_sched.sv
// dc_derr_sched: macroblock sequencer and error-state owner for the
// chroma DC datapath. Optional watchdog: define DCCORR_WDOG_EN.
module dc_derr_sched
    import dc_derr_sched_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_x,
    input  logic [Y_W-1:0]      req_y,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ADDR_W-1:0]   resp_x,
    output logic [Y_W-1:0]      resp_y,
    output logic                resp_err,
    output logic                dp_start,
    output logic [ADDR_W-1:0]   dp_x,
    output logic [Y_W-1:0]      dp_y,
    input  logic                dp_top_derr_en,
    input  logic [ADDR_W-1:0]   dp_top_derr_addr,
    output logic [WORD_W-1:0]   dp_top_derr,
    output logic [WORD_W-1:0]   dp_left_derr,
    input  logic [BUNDLE_W-1:0] dp_derr,
    input  logic                dp_done
);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_dp_start;
    logic                r_resp_valid;
    logic [ADDR_W-1:0]   r_dp_x;
    logic [Y_W-1:0]      r_dp_y;
    logic [ADDR_W-1:0]   r_resp_x;
    logic [Y_W-1:0]      r_resp_y;
    logic [WORD_W-1:0]   r_left;

    logic                w_accept;
    logic                w_wb;
    logic [WORD_W-1:0]   w_top_word;
    logic [WORD_W-1:0]   w_left_word;

    assign w_accept = req_valid && r_req_ready && (r_state == S_IDLE);

    // A reset on the completion edge discards the writeback
    assign w_wb = rst_n && (r_state == S_BUSY) && dp_done;

    assign w_top_word  = pack_word(dp_derr, TOP_L3, TOP_L2,
                                   TOP_L1, TOP_L0);
    assign w_left_word = pack_word(dp_derr, LEFT_L3, LEFT_L2,
                                   LEFT_L1, LEFT_L0);

`ifdef DCCORR_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_resp_err;
    logic              w_wdog_hit;

    assign w_wdog_hit = (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

    // Count consecutive BUSY cycles; cleared whenever BUSY is left
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_BUSY) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    // Abort flag rides with the response it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_err <= 1'b0;
        end else if (r_state == S_ERR) begin
            r_resp_err <= 1'b1;
        end else if (r_state == S_RESP && resp_ready) begin
            r_resp_err <= 1'b0;
        end
    end

    assign resp_err = r_resp_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = ^WDOG_CYCLES;
    assign resp_err      = 1'b0;
`endif

    // Request FSM with registered handshake and start outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_dp_start   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_dp_x       <= '0;
            r_dp_y       <= '0;
            r_resp_x     <= '0;
            r_resp_y     <= '0;
            r_left       <= '0;
        end else begin
            r_dp_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_START;
                        r_req_ready <= 1'b0;
                        r_dp_start  <= 1'b1;
                        r_dp_x      <= req_x;
                        r_dp_y      <= req_y;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (dp_done) begin
                        r_state      <= S_RESP;
                        r_left       <= w_left_word;
                        r_resp_valid <= 1'b1;
                        r_resp_x     <= r_dp_x;
                        r_resp_y     <= r_dp_y;
                    end
`ifdef DCCORR_WDOG_EN
                    else if (w_wdog_hit) begin
                        r_state <= S_ERR;
                    end
`endif
                end
`ifdef DCCORR_WDOG_EN
                S_ERR: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_x     <= r_dp_x;
                    r_resp_y     <= r_dp_y;
                end
`endif
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b0;
                end
            endcase
        end
    end

    derr_line_ram #(
        .AW (ADDR_W),
        .DW (WORD_W)
    ) u_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wb),
        .i_waddr (r_dp_x),
        .i_wdata (w_top_word),
        .i_re    (dp_top_derr_en),
        .i_raddr (dp_top_derr_addr),
        .o_rdata (dp_top_derr)
    );

    assign req_ready    = r_req_ready;
    assign dp_start     = r_dp_start;
    assign dp_x         = r_dp_x;
    assign dp_y         = r_dp_y;
    assign resp_valid   = r_resp_valid;
    assign resp_x       = r_resp_x;
    assign resp_y       = r_resp_y;
    assign dp_left_derr = r_left;

endmodule

// File: tb/tb_dc_derr_sched.sv
// tb_dc_derr_sched: scoreboard bench for dc_derr_sched.
// Covers DCCORR_WDOG_EN when that macro is defined.
module tb_dc_derr_sched;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_x;
    logic [9:0]    req_y;
    logic          resp_valid;
    logic          resp_ready;
    logic [AW-1:0] resp_x;
    logic [9:0]    resp_y;
    logic          resp_err;
    logic          dp_start;
    logic [AW-1:0] dp_x;
    logic [9:0]    dp_y;
    logic          dp_top_derr_en;
    logic [AW-1:0] dp_top_derr_addr;
    logic [31:0]   dp_top_derr;
    logic [31:0]   dp_left_derr;
    logic [47:0]   dp_derr;
    logic          dp_done;

    dc_derr_sched #(
        .ADDR_W      (AW),
        .WDOG_CYCLES (20)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_x            (req_x),
        .req_y            (req_y),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_x           (resp_x),
        .resp_y           (resp_y),
        .resp_err         (resp_err),
        .dp_start         (dp_start),
        .dp_x             (dp_x),
        .dp_y             (dp_y),
        .dp_top_derr_en   (dp_top_derr_en),
        .dp_top_derr_addr (dp_top_derr_addr),
        .dp_top_derr      (dp_top_derr),
        .dp_left_derr     (dp_left_derr),
        .dp_derr          (dp_derr),
        .dp_done          (dp_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] x;
        logic [9:0]    y;
        logic          err;
        logic [31:0]   left;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] line_m[int];
    logic [31:0] last_left;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] top_of(input logic [47:0] d);
        return {d[47:40], d[39:32], d[23:16], d[15:8]};
    endfunction

    function automatic logic [31:0] left_of(input logic [47:0] d);
        return {d[47:40], d[31:24], d[23:16], d[7:0]};
    endfunction

    // Response monitor: pops the scoreboard on each accepted response
    initial begin
        forever begin
            resp_t e;
            @(negedge clk);
            #1;
            if (rst_n && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_x", resp_x, e.x);
                    check("resp_y", resp_y, e.y);
                    check("resp_err", resp_err, e.err);
                    check("resp_left", dp_left_derr, e.left);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a);
        dp_top_derr_en   = 1'b1;
        dp_top_derr_addr = a;
        @(negedge clk);
        dp_top_derr_en = 1'b0;
        check(tag, dp_top_derr, line_m[int'(a)]);
    endtask

    task automatic push_exp(input logic [AW-1:0] x, input logic [9:0] y,
                            input logic err, input logic [31:0] left);
        resp_t e;
        e.x    = x;
        e.y    = y;
        e.err  = err;
        e.left = left;
        sb.push_back(e);
    endtask

    task automatic do_req(input logic [AW-1:0] x, input logic [9:0] y,
                          input logic [47:0] d, input int done_c,
                          input int hold);
        logic [31:0] old;
        logic        have_old;
        wait_ready();
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        resp_ready = (hold == 0);
        push_exp(x, y, 1'b0, left_of(d));
        have_old = 1'b0;
        old      = '0;
        for (int c = 1; c <= done_c + 1 + hold; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                check("dp_start_c1", dp_start, 1);
                check("dp_x", dp_x, x);
                check("dp_y", dp_y, y);
            end
            if (c == 2) check("dp_start_c2", dp_start, 0);
            if (c == 3 && y != 0) begin
                dp_top_derr_en   = 1'b1;
                dp_top_derr_addr = x;
            end
            if (c == 4 && y != 0) begin
                dp_top_derr_en = 1'b0;
                check("top_read", dp_top_derr, line_m[int'(x)]);
                check("left_stable", dp_left_derr, last_left);
            end
            if (c == done_c) begin
                check("no_early_resp", resp_valid, 0);
                dp_done          = 1'b1;
                dp_derr          = d;
                dp_top_derr_en   = 1'b1;
                dp_top_derr_addr = x;
                have_old         = line_m.exists(int'(x));
                if (have_old) old = line_m[int'(x)];
            end
            if (c == done_c + 1) begin
                dp_done        = 1'b0;
                dp_top_derr_en = 1'b0;
                if (have_old) check("collide_old", dp_top_derr, old);
                line_m[int'(x)] = top_of(d);
                last_left       = left_of(d);
            end
            if (c >= done_c + 1) begin
                check("resp_valid", resp_valid, 1);
                check("req_ready_busy", req_ready, 0);
                if (c < done_c + 1 + hold) begin
                    req_valid = 1'b1;
                end else begin
                    req_valid  = 1'b0;
                    resp_ready = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("req_ready_back", req_ready, 1);
        check("dp_start_idle", dp_start, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int stray;
        rst_n            = 1'b0;
        req_valid        = 1'b0;
        req_x            = '0;
        req_y            = '0;
        resp_ready       = 1'b1;
        dp_top_derr_en   = 1'b0;
        dp_top_derr_addr = '0;
        dp_derr          = '0;
        dp_done          = 1'b0;
        last_left        = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_xy", {resp_x, resp_y}, 0);
        check("rst_dp_xy", {dp_x, dp_y}, 0);
        check("rst_left", dp_left_derr, 0);
        check("rst_top", dp_top_derr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        // Corner block: row 0 and column 0
        do_req(10'd0, 10'd0, 48'h06_05_04_03_02_01, 13, 0);
        check("left_0_0", dp_left_derr, 32'h06040301);
        rd_chk("line0", 10'd0);
        check("line0_const", dp_top_derr, 32'h06050302);

        // Preload column 3, then read it back from row 1
        do_req(10'd3, 10'd0, 48'hA1_B2_00_C3_D4_00, 13, 0);
        check("line3_pre", line_m[3], 32'hA1B2C3D4);
        do_req(10'd3, 10'd1, 48'h11_22_33_44_55_66, 15, 0);

        // Back-pressure on the response
        do_req(10'd5, 10'd2, 48'h80_7F_FF_01_9C_E4, 15, 5);

        // Stray completion while idle must change nothing
        dp_done = 1'b1;
        dp_derr = {6{8'h7F}};
        @(negedge clk);
        dp_done = 1'b0;
        @(negedge clk);
        check("stray_left", dp_left_derr, last_left);
        rd_chk("stray_line3", 10'd3);
        rd_chk("stray_line5", 10'd5);

        // Reset at cycle 8 with a completion on the same edge
        wait_ready();
        req_valid = 1'b1;
        req_x     = 10'd3;
        req_y     = 10'd1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        rst_n   = 1'b0;
        dp_done = 1'b1;
        dp_derr = {6{8'hEE}};
        @(negedge clk);
        rst_n   = 1'b1;
        dp_done = 1'b0;
        check("mid_rst_left", dp_left_derr, 0);
        check("mid_rst_resp", resp_valid, 0);
        check("mid_rst_start", dp_start, 0);
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check("mid_rst_no_resp", stray, 0);
        last_left = '0;
        do_req(10'd9, 10'd4, 48'h0A_0B_0C_0D_0E_0F, 15, 0);
        rd_chk("mid_rst_line3", 10'd3);

`ifdef DCCORR_WDOG_EN
        // Datapath never completes: abort after 20 BUSY cycles plus ERR
        wait_ready();
        req_valid = 1'b1;
        req_x     = 10'd3;
        req_y     = 10'd1;
        push_exp(10'd3, 10'd1, 1'b1, last_left);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 22) check("wdog_not_yet", resp_valid, 0);
            if (c == 23) check("wdog_resp", resp_valid, 1);
        end
        @(negedge clk);
        check("wdog_ready", req_ready, 1);
        check("wdog_drained", sb.size(), 0);
        rd_chk("wdog_line3", 10'd3);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
